// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial add controller: FSM state encoding,
// operand width limits and the counter-width helper.
// No ports; also provides the WIDTH range-check macro used by the top.

`ifndef SERIAL_ADDER_CTRL_PKG_SV
`define SERIAL_ADDER_CTRL_PKG_SV

// Elaboration-time guard: instantiating with an unsupported WIDTH stops the build.
`define SAC_CHECK_WIDTH(w) \
  if (((w) < WIDTH_MIN) || ((w) > WIDTH_MAX)) begin : g_width_check \
    $error("serial_adder_ctrl: WIDTH must be within 1..64"); \
  end

package serial_adder_ctrl_pkg;

  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit-position counter width; a 1-bit operand still needs a 1-bit counter.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

`endif

// File: rtl/serial_adder_ctrl_full_adder.sv
// Purpose: single-bit full adder shared by the serial add controller.
// Latency: combinational. Backpressure: none.
// Ports: a, b, cin (bit inputs) -> sum (a^b^cin), count (carry out).

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic count
);

  assign sum   = a ^ b ^ cin;
  assign count = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Purpose: bit-serial adder; one full_adder reused LSB-first, one bit per clock.
// Latency: start accepted at edge t -> done pulses in the cycle after edge t+WIDTH.
// Backpressure: start is sampled only in IDLE/DONE; requests during RUN are dropped.
// Ports: clk, rst (sync, active-high); start/a/b/cin request; busy while running;
//        done one-cycle pulse; sum/cout/overflow registered and held until the next result.

module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  `SAC_CHECK_WIDTH(WIDTH)

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_nx;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_cout;
  logic             msb_cin;

  full_adder u_fa (
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .cin   (carry),
    .sum   (fa_sum),
    .count (fa_cout)
  );

  // Result bits enter at the MSB and drift down, so after WIDTH steps bit 0
  // holds the LSB. Works unchanged for WIDTH=1 (the shift just empties).
  always_comb begin
    sum_nx            = sum_sh >> 1;
    sum_nx[WIDTH-1]   = fa_sum;
  end

  // On the last step the carry flop holds the carry into the MSB; it is
  // consumed in that same cycle, so no separate storage is needed.
  assign msb_cin = carry;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      a_sh     <= '0;
      b_sh     <= '0;
      sum_sh   <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            sum_sh <= '0;
            carry  <= cin;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= ST_RUN;
          end else begin
            busy   <= 1'b0;
            state  <= ST_IDLE;
          end
        end

        ST_RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= sum_nx;
          carry  <= fa_cout;
          if (cnt == CNT_LAST) begin
            // Counter is left at its final value; it is cleared on the next accept.
            sum      <= sum_nx;
            cout     <= fa_cout;
            overflow <= msb_cin ^ fa_cout;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= ST_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl at WIDTH=8, 13 and 1 with a queue scoreboard.
// Expected results come from plain integer addition of the accepted operands.

module tb_serial_adder_ctrl;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    int          acc;   // edge index at which start was accepted
    int          dn;    // cycle index (edges seen) in which done must be high
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start_v [3];
  logic [63:0] a_v     [3];
  logic [63:0] b_v     [3];
  logic        cin_v   [3];

  logic        busy8, done8, cout8, ovf8;
  logic [7:0]  sum8;
  logic        busy13, done13, cout13, ovf13;
  logic [12:0] sum13;
  logic        busy1, done1, cout1, ovf1;
  logic [0:0]  sum1;

  exp_t        q [3][$];
  int          free_edge [3];
  int          accepts   [3];
  logic [63:0] last_sum  [3];
  logic        last_cout [3];
  logic        last_ovf  [3];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start_v[0]), .a(a_v[0][7:0]), .b(b_v[0][7:0]),
    .cin(cin_v[0]), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8)
  );

  serial_adder_ctrl #(.WIDTH(13)) dut13 (
    .clk(clk), .rst(rst), .start(start_v[1]), .a(a_v[1][12:0]), .b(b_v[1][12:0]),
    .cin(cin_v[1]), .busy(busy13), .done(done13), .sum(sum13), .cout(cout13), .overflow(ovf13)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start_v[2]), .a(a_v[2][0:0]), .b(b_v[2][0:0]),
    .cin(cin_v[2]), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .overflow(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wof(input int k);
    case (k)
      0:       return 8;
      1:       return 13;
      default: return 1;
    endcase
  endfunction

  // Reference: integer sum of the operands; signed overflow when both
  // operands share a sign that the result does not.
  function automatic exp_t model(input int w, input logic [63:0] av, input logic [63:0] bv,
                                 input logic c);
    exp_t        r;
    logic [63:0] m;
    logic [64:0] s;
    m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    s = {1'b0, av & m} + {1'b0, bv & m} + {64'd0, c};
    r.sum  = s[63:0] & m;
    r.cout = s[w];
    r.ovf  = (av[w-1] == bv[w-1]) && (r.sum[w-1] != av[w-1]);
    r.acc  = 0;
    r.dn   = 0;
    return r;
  endfunction

  task automatic cmp(input string nm, input int k, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s w=%0d cyc=%0d got %h expected %h", nm, wof(k), cyc, act, expv);
    end
  endtask

  task automatic chk(input int k, input logic dn, input logic bz, input logic [63:0] s,
                     input logic co, input logic ov);
    exp_t e;
    logic bexp;
    while (q[k].size() > 0 && q[k][0].dn < cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_done w=%0d cyc=%0d got no done expected done at %0d",
               wof(k), cyc, q[k][0].dn);
      void'(q[k].pop_front());
    end
    bexp = (q[k].size() > 0) && (q[k][0].acc <= cyc) && (cyc < q[k][0].dn);
    cmp("busy", k, {63'd0, bz}, {63'd0, bexp});
    if (dn) begin
      if (q[k].size() == 0 || q[k][0].dn != cyc) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done w=%0d cyc=%0d got done=1 expected done=0", wof(k), cyc);
      end else begin
        e = q[k].pop_front();
        cmp("sum", k, s, e.sum);
        cmp("cout", k, {63'd0, co}, {63'd0, e.cout});
        cmp("overflow", k, {63'd0, ov}, {63'd0, e.ovf});
        last_sum[k]  = e.sum;
        last_cout[k] = e.cout;
        last_ovf[k]  = e.ovf;
      end
    end else begin
      cmp("hold_sum", k, s, last_sum[k]);
      cmp("hold_cout", k, {63'd0, co}, {63'd0, last_cout[k]});
      cmp("hold_ovf", k, {63'd0, ov}, {63'd0, last_ovf[k]});
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk(0, done8,  busy8,  64'(sum8),  cout8,  ovf8);
      chk(1, done13, busy13, 64'(sum13), cout13, ovf13);
      chk(2, done1,  busy1,  64'(sum1),  cout1,  ovf1);
    end
  end

  // Advance one clock; if that edge sampled reset, the model forgets everything.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        q[k].delete();
        free_edge[k] = cyc + 1;
        last_sum[k]  = '0;
        last_cout[k] = 1'b0;
        last_ovf[k]  = 1'b0;
      end
    end
  endtask

  // Drive inputs for the coming edge; the model accepts the request only if
  // the previous operation has reached its done cycle.
  task automatic set_in(input int k, input bit st, input logic [63:0] av, input logic [63:0] bv,
                        input bit c);
    exp_t e;
    start_v[k] = st;
    a_v[k]     = av;
    b_v[k]     = bv;
    cin_v[k]   = c;
    if (st && !rst && (cyc + 1) >= free_edge[k]) begin
      e     = model(wof(k), av, bv, c);
      e.acc = cyc + 1;
      e.dn  = cyc + 1 + wof(k);
      q[k].push_back(e);
      free_edge[k] = e.dn + 1;
      accepts[k]++;
    end
  endtask

  task automatic drain(input int k);
    for (int i = 0; i < 200 && q[k].size() > 0; i++) tick();
    if (q[k].size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout w=%0d got %0d pending expected 0", wof(k), q[k].size());
    end
    tick();
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    int a1;
    int base [3];
    bit all_done;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_in(k, 1'b0, '0, '0, 1'b0);
      accepts[k] = 0;
    end
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    cmp("rst_busy", 0, {63'd0, busy8}, 64'd0);
    cmp("rst_done", 0, {63'd0, done8}, 64'd0);
    cmp("rst_sum", 0, 64'(sum8), 64'd0);
    cmp("rst_cout", 0, {63'd0, cout8}, 64'd0);
    cmp("rst_ovf", 0, {63'd0, ovf8}, 64'd0);
    cmp("rst_sum13", 1, 64'(sum13), 64'd0);
    cmp("rst_busy1", 2, {63'd0, busy1}, 64'd0);
    mon_en = 1'b1;
    tick();

    // Directed arithmetic cases.
    set_in(0, 1'b1, 64'h3C, 64'h55, 1'b0); tick(); set_in(0, 1'b0, '0, '0, 1'b0); drain(0);
    set_in(0, 1'b1, 64'hFF, 64'h01, 1'b0); tick(); set_in(0, 1'b0, '0, '0, 1'b0); drain(0);
    set_in(0, 1'b1, 64'h7F, 64'h00, 1'b1); tick(); set_in(0, 1'b0, '0, '0, 1'b0); drain(0);

    // start held with operands changing every cycle: only accept-cycle values count.
    for (int i = 0; i < 27; i++) begin
      set_in(0, 1'b1, rnd64(), rnd64(), 1'($urandom_range(0, 1)));
      tick();
    end
    set_in(0, 1'b0, '0, '0, 1'b0);
    drain(0);

    // Back-to-back: new request offered in the DONE cycle must be taken at once.
    set_in(0, 1'b1, 64'h10, 64'h20, 1'b0);
    tick();
    a1 = accepts[0];
    for (int i = 0; i < 20; i++) begin
      set_in(0, 1'b1, 64'h01, 64'h02, 1'b0);
      tick();
      if (accepts[0] != a1) break;
    end
    set_in(0, 1'b0, '0, '0, 1'b0);
    drain(0);

    // Reset three cycles into RUN aborts silently; the next request works.
    set_in(0, 1'b1, 64'hA5, 64'h5A, 1'b1);
    tick();
    set_in(0, 1'b0, '0, '0, 1'b0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    set_in(0, 1'b1, 64'h22, 64'h33, 1'b0); tick(); set_in(0, 1'b0, '0, '0, 1'b0); drain(0);

    // Single-bit instance.
    set_in(2, 1'b1, 64'h1, 64'h1, 1'b1); tick(); set_in(2, 1'b0, '0, '0, 1'b0); drain(2);

    // Random traffic on all three widths until each has taken 1000 operations.
    for (int k = 0; k < 3; k++) base[k] = accepts[k];
    all_done = 1'b0;
    for (int i = 0; i < 40000 && !all_done; i++) begin
      all_done = 1'b1;
      for (int k = 0; k < 3; k++) begin
        if (accepts[k] - base[k] < 1000) begin
          all_done = 1'b0;
          set_in(k, $urandom_range(0, 3) != 0, rnd64(), rnd64(), 1'($urandom_range(0, 1)));
        end else begin
          set_in(k, 1'b0, '0, '0, 1'b0);
        end
      end
      tick();
    end
    if (!all_done) begin
      checks++;
      errors++;
      $display("FAIL random_budget got %0d/%0d/%0d ops expected 1000 each",
               accepts[0] - base[0], accepts[1] - base[1], accepts[2] - base[2]);
    end
    for (int k = 0; k < 3; k++) set_in(k, 1'b0, '0, '0, 1'b0);
    for (int k = 0; k < 3; k++) drain(k);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
